multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  op  in  6  instruction opcode, bits 31:26, from the instruction register
  funct  in  6  instruction funct, bits 5:0
  zero  in  1  ALU zero flag
  ALUControl  out  3  ALU function code: 010 add, 110 sub, 000 and, 001 or, 111 slt
  ALUSrcA  out  1  0 = PC, 1 = register A
  ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
  PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
  IorD, RegDst, MemtoReg  out  1 each  datapath mux selects
  IRWrite, MemWrite, RegWrite, PCEn  out  1 each  write strobes
  illegal  out  1  one-cycle pulse on an unsupported opcode

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX; the state SHALL advance every clock cycle, with no stalls.
REQ-004 Opcodes SHALL be: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-005 Transitions SHALL be:
  FETCH -> DECODE.
  DECODE -> MEMADR for lw or sw; RTYPEEX for R-type; BEQEX for beq; ADDIEX for addi; JEX for j; FETCH for any other opcode.
  MEMADR -> MEMRD for lw; MEMWR for sw.
  MEMRD -> MEMWB -> FETCH.
  RTYPEEX -> RTYPEWB -> FETCH.
  ADDIEX -> ADDIWB -> FETCH.
  MEMWR, BEQEX and JEX -> FETCH.
REQ-006 Outputs not listed for a state SHALL be 0. Per-state outputs SHALL be:
  FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00, IRWrite=1, PCWrite=1.
  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add.
  MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=add.
  MEMRD: IorD=1.
  MEMWB: MemtoReg=1, RegWrite=1.
  MEMWR: IorD=1, MemWrite=1.
  RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=funct.
  RTYPEWB: RegDst=1, RegWrite=1.
  BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01, Branch=1.
  ADDIWB: RegWrite=1.
  JEX: PCSrc=10, PCWrite=1.
REQ-007 PCEn SHALL equal PCWrite OR (Branch AND zero), evaluated combinationally within the same cycle.
REQ-008 ALUControl SHALL be 010 for ALUOp add and 110 for ALUOp sub.
REQ-009 For ALUOp funct, ALUControl SHALL map funct as follows: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
REQ-010 illegal SHALL be 1 only in DECODE with an unsupported opcode, for exactly one cycle; no write strobe SHALL assert for that instruction.
REQ-011 An unsupported funct in RTYPEEX SHALL NOT assert illegal; the register writeback in RTYPEWB still occurs.
REQ-012 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; unsupported opcode 2 cycles.

Reset
REQ-013 A cycle with reset=1 SHALL place the state in FETCH at the next clock edge, from any state, including mid-instruction.
REQ-014 While reset=1, IRWrite, MemWrite, RegWrite, PCEn and illegal SHALL be forced to 0; all other outputs SHALL take their FETCH values.
REQ-015 The first cycle after reset deasserts SHALL be a FETCH with active strobes.

Structure
REQ-016 A shared package SHALL hold the state enumeration, the opcode constants, the ALUOp encoding (add 00, sub 01, funct 10) and the ALUControl codes.
REQ-017 The funct-to-ALUControl mapping SHALL be a separate combinational sub-module, alu_decoder, driven by ALUOp and funct.
REQ-018 The state register SHALL be the only sequential element.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  lw (op 100011) from reset -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5; back in FETCH in cycle 6.
  beq (op 000100) with zero=1 in BEQEX -> PCEn=1, PCSrc=01, ALUControl=110; with zero=0 -> PCEn=0.
  R-type with funct 101010 -> ALUControl=111 in RTYPEEX, then RegDst=1 and RegWrite=1 in RTYPEWB.
  op 111111 -> illegal=1 in DECODE only; no strobes asserted; next state FETCH.
  reset asserted during MEMWR -> MemWrite=0 that cycle, FETCH on the next edge, IRWrite=1 once reset deasserts.
  j (op 000010) -> PCEn=1 and PCSrc=10 in JEX; 3-cycle total latency.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle processor controller.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // True for every opcode the controller knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALUOp/funct to ALUControl mapping.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Unknown funct codes fall back to add so an R-type still produces a result.
  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALUC_ADD;
          FUNCT_SUB: alu_control = ALUC_SUB;
          FUNCT_AND: alu_control = ALUC_AND;
          FUNCT_OR:  alu_control = ALUC_OR;
          FUNCT_SLT: alu_control = ALUC_SLT;
          default:   alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for a multicycle MIPS-subset datapath.
//
// state   | meaning
// --------+---------------------------------------------------
// FETCH   | read instruction, PC <= PC + 4
// DECODE  | read registers, precompute branch target
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory (lw)
// MEMWB   | write loaded word to register file (lw)
// MEMWR   | write data memory (sw)
// RTYPEEX | ALU operation selected by funct
// RTYPEWB | write ALU result to rd
// BEQEX   | compare registers, take branch on zero
// ADDIEX  | add sign-extended immediate
// ADDIWB  | write addi result to rt
// JEX     | load jump target into PC
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       illegal
);

  state_t state_q, state_d;
  state_t out_state;
  aluop_t alu_op;
  logic   pc_write, branch;
  logic   ir_write, mem_write, reg_write, illegal_op;

  // State register; the only storage in the block.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; every state advances each cycle.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // While reset is high the mux selects show FETCH values so the datapath is
  // already steered correctly for the first real fetch.
  assign out_state = reset ? FETCH : state_q;

  // Per-state Moore output decode (strobes masked by reset below).
  always_comb begin
    alu_op     = ALUOP_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (out_state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !op_supported(op);
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      JEX: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite  = ir_write  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign PCEn     = (pc_write | (branch & zero)) & ~reset;
  assign illegal  = illegal_op & ~reset;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (ALUControl)
  );

endmodule
